// File: rtl/instruction_fetch_stage_if.sv
// instruction_fetch_stage_if: instruction memory req/ready/valid bus
interface instruction_fetch_stage_if;
  logic        req;
  logic [31:0] address;
  logic        ready;
  logic        valid;
  logic [31:0] data;
  modport master(output req, address, input ready, valid, data);
  modport slave(input req, address, output ready, valid, data);
endinterface

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC owner, single-outstanding imem fetch, IF/ID register
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_stall,
  input  logic                              i_flush,
  input  logic                              i_pc_src,
  input  logic [31:0]                       i_branch_target,
  input  logic                              i_jump_reg,
  input  logic [31:0]                       i_jump_reg_target,
  input  logic                              i_jump,
  input  logic [31:0]                       i_jump_target,
  instruction_fetch_stage_if.master         imem,
  output logic [31:0]                       o_instruction,
  output logic [31:0]                       o_pc_add_result,
  output logic                              o_instr_valid
);
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN, S_HOLD} state_t;
  state_t      r_state, w_next_state;
  logic [31:0] r_pc, r_req_pc, r_hold_data;
  logic [31:0] w_next_pc, w_target, w_req_pc4, w_deliver_data;
  logic        w_redirect, w_accept, w_deliver, w_capture;
  assign w_redirect = i_pc_src | i_jump_reg | i_jump;
  assign w_target   = (i_pc_src ? i_branch_target : i_jump_reg ? i_jump_reg_target : i_jump_target) & ~32'h3;
  assign w_req_pc4  = r_req_pc + 32'd4;
  assign imem.req     = (r_state == S_FETCH) & ~rst;
  assign imem.address = r_pc;
  // next state, next PC and delivery decisions; the older redirect source wins the target
  always_comb begin
    w_next_state   = r_state;
    w_next_pc      = w_redirect ? w_target : r_pc;
    w_accept       = 1'b0;
    w_deliver      = 1'b0;
    w_capture      = 1'b0;
    w_deliver_data = r_hold_data;
    case (r_state)
      S_FETCH: begin
        w_accept     = imem.ready;
        w_next_state = imem.ready ? (w_redirect ? S_DRAIN : S_WAIT) : S_FETCH;
      end
      S_WAIT: begin
        if (w_redirect) w_next_state = imem.valid ? S_FETCH : S_DRAIN;
        else if (imem.valid && !i_stall) begin
          w_deliver      = 1'b1;
          w_deliver_data = imem.data;
          w_next_pc      = w_req_pc4;
          w_next_state   = S_FETCH;
        end else if (imem.valid) begin
          w_capture    = 1'b1;
          w_next_state = S_HOLD;
        end
      end
      S_DRAIN: w_next_state = imem.valid ? S_FETCH : S_DRAIN;
      S_HOLD: begin
        if (w_redirect) w_next_state = S_FETCH;
        else if (!i_stall) begin
          w_deliver    = 1'b1;
          w_next_pc    = w_req_pc4;
          w_next_state = S_FETCH;
        end
      end
      default: w_next_state = S_FETCH;
    endcase
  end
  // fetch state, PC and the accepted-request bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= {RESET_PC[31:2], 2'b00};
      r_req_pc    <= '0;
      r_hold_data <= '0;
    end else begin
      r_state     <= w_next_state;
      r_pc        <= w_next_pc;
      r_req_pc    <= w_accept ? r_pc : r_req_pc;
      r_hold_data <= w_capture ? imem.data : r_hold_data;
    end
  end
  // IF/ID register: flush beats stall beats delivery, otherwise a NOP bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_instruction   <= '0;
      o_pc_add_result <= '0;
      o_instr_valid   <= 1'b0;
    end else if (i_flush || (!i_stall && !w_deliver)) begin
      o_instruction <= '0;
      o_instr_valid <= 1'b0;
    end else if (!i_stall) begin
      o_instruction   <= w_deliver_data;
      o_pc_add_result <= w_req_pc4;
      o_instr_valid   <= 1'b1;
    end
  end
endmodule
